// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the baud divider derivation used by both receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int unsigned OVS         = 16;
    localparam int unsigned SAMPLE_MID  = 7;
    localparam int unsigned STOP_SAMPLE = 9;

    // Clocks per oversample tick for a given system clock and line rate.
    function automatic int unsigned tick_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / (OVS * baud);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..TICK_DIV-1 and pulses tick for one
// cycle on the last count. clear restarts the count so the tick phase can be
// aligned to a detected start edge.
module uart_baud_tick #(
    parameter int unsigned TICK_DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // Free-running divider, realigned by clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST) && !clear;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote per bit,
// stop-bit check and a level DONE / TRG_READ byte handshake with sticky
// frame-error and overrun flags.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned TICK_DIV = tick_div(CLK_HZ, BAUD)
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       RX,
    input  logic       TRG_READ,
    output logic [7:0] DATA_OUT,
    output logic       DONE,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       BUSY
);

    localparam int unsigned SW = $clog2(OVS);
    localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
    localparam logic [SW-1:0] S_WBEG = SW'(SAMPLE_MID);
    localparam logic [SW-1:0] S_WEND = SW'(SAMPLE_MID + 2);
    localparam logic [SW-1:0] S_STOP = SW'(STOP_SAMPLE);

    logic          rx_meta;
    logic          rx_s;
    logic [1:0]    sync_fill;
    rx_state_t     state_q;
    rx_state_t     state_d;
    logic          tick;
    logic          tick_clear;
    logic [SW-1:0] sample_cnt;
    logic [2:0]    bit_idx;
    logic [2:0]    votes;
    logic [7:0]    rx_byte;
    logic          maj_stored;
    logic          maj_stop;
    logic          at_last;
    logic          at_stop;
    logic          in_window;
    logic          shift_en;
    logic          deliver;
    logic          frame_fail;

    // Two-flop synchronizer; sync_fill marks when rx_s reflects the real line
    // again after reset, since the reset value of 1 would otherwise be taken
    // as an idle line and a low RX at release would look like a start bit.
    always_ff @(posedge CLK_50MHZ) begin
        if (!RST) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            sync_fill <= '0;
        end else begin
            rx_meta   <= RX;
            rx_s      <= rx_meta;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    uart_baud_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (CLK_50MHZ),
        .rst_n(RST),
        .clear(tick_clear),
        .tick (tick)
    );

    assign at_last   = tick && (sample_cnt == S_LAST);
    assign at_stop   = tick && (sample_cnt == S_STOP);
    assign in_window = tick && (sample_cnt >= S_WBEG) && (sample_cnt <= S_WEND);

    // Stored votes hold samples 7,8,9; the stop decision at sample 9 uses the
    // two stored samples plus the live synchronized line.
    assign maj_stored = (votes[2] & votes[1]) | (votes[2] & votes[0]) | (votes[1] & votes[0]);
    assign maj_stop   = (votes[1] & votes[0]) | (votes[1] & rx_s) | (votes[0] & rx_s);

    assign BUSY = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    // State register.
    always_ff @(posedge CLK_50MHZ) begin
        if (!RST) begin
            state_q <= WAIT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-cycle frame events.
    always_comb begin
        state_d    = state_q;
        tick_clear = 1'b0;
        shift_en   = 1'b0;
        deliver    = 1'b0;
        frame_fail = 1'b0;
        case (state_q)
            WAIT_IDLE: begin
                if (rx_s && sync_fill[1]) state_d = IDLE;
            end
            IDLE: begin
                if (!rx_s) begin
                    state_d    = START;
                    tick_clear = 1'b1;
                end
            end
            START: begin
                if (at_last) state_d = maj_stored ? IDLE : DATA;
            end
            DATA: begin
                if (at_last) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (at_stop) begin
                    if (maj_stop) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_fail = 1'b1;
                        state_d    = WAIT_IDLE;
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    // Sample counter, vote capture and LSB-first byte assembly.
    always_ff @(posedge CLK_50MHZ) begin
        if (!RST) begin
            sample_cnt <= '0;
            bit_idx    <= '0;
            votes      <= '0;
            rx_byte    <= '0;
        end else begin
            if (!BUSY) begin
                sample_cnt <= '0;
            end else if (tick) begin
                sample_cnt <= sample_cnt + 1'b1;
            end
            if (in_window) votes <= {votes[1:0], rx_s};
            if (state_q == START) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (shift_en) rx_byte[bit_idx] <= maj_stored;
        end
    end

    // Byte handshake; later assignments take priority (frame error sets
    // FRAME_ERR even when a read clears it in the same cycle).
    always_ff @(posedge CLK_50MHZ) begin
        if (!RST) begin
            DATA_OUT  <= '0;
            DONE      <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            if (TRG_READ) begin
                FRAME_ERR <= 1'b0;
                OVERRUN   <= 1'b0;
            end
            if (deliver) begin
                if (!DONE || TRG_READ) begin
                    DATA_OUT <= rx_byte;
                    DONE     <= 1'b1;
                end else begin
                    OVERRUN <= 1'b1;
                end
            end else if (TRG_READ) begin
                DONE <= 1'b0;
            end
            if (frame_fail) FRAME_ERR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: a timing model predicts every output from the
// recorded line history (frame start edge plus tick arithmetic), checked on
// every cycle, with directed scenarios pinned by literal expectations and a
// randomized frame/read/gap phase.
module tb_uart_receiver;

    localparam int TD    = 4;
    localparam int BITC  = 16 * TD;
    localparam int FRAME = 10 * BITC;
    localparam int DLV   = 154 * TD + 2;   // drive offset that lands TRG_READ on the delivery edge
    localparam int HMAX  = 65536;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       trg;
    logic [7:0] data_out;
    logic       done;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    uart_receiver #(
        .TICK_DIV(TD)
    ) dut (
        .CLK_50MHZ(clk),
        .RST      (rst),
        .RX       (rx),
        .TRG_READ (trg),
        .DATA_OUT (data_out),
        .DONE     (done),
        .FRAME_ERR(frame_err),
        .OVERRUN  (overrun),
        .BUSY     (busy)
    );

    // ---------------- reference model ----------------
    bit         rx_at [0:HMAX-1];
    int         edge_n     = 0;
    int         m_mode     = 0;   // 0 waiting for high line, 1 idle, 2 receiving
    int         m_start    = 0;
    int         m_rst_edge = 0;
    logic [7:0] m_data     = 8'h00;
    bit         m_done     = 1'b0;
    bit         m_fe       = 1'b0;
    bit         m_ov       = 1'b0;

    // Majority of the line seen at ticks t0..t0+2 after the frame start edge.
    function automatic bit line_maj(int s, int t0);
        int n;
        n = 0;
        for (int t = t0; t < t0 + 3; t++) n += int'(rx_at[s + t * TD - 2]);
        return n >= 2;
    endfunction

    always @(posedge clk) begin : model
        bit         dlv;
        bit         fail;
        logic [7:0] b;
        int         k;
        edge_n++;
        if (edge_n >= HMAX) begin
            $display("FAIL history_overflow: edge %0d exceeds %0d", edge_n, HMAX);
            $fatal(1);
        end
        rx_at[edge_n] = rx;
        dlv  = 1'b0;
        fail = 1'b0;
        b    = 8'h00;
        if (!rst) begin
            m_mode     = 0;
            m_rst_edge = edge_n;
            m_data     = 8'h00;
            m_done     = 1'b0;
            m_fe       = 1'b0;
            m_ov       = 1'b0;
        end else begin
            case (m_mode)
                0: if (edge_n >= m_rst_edge + 3 && rx_at[edge_n - 2]) m_mode = 1;
                1: if (!rx_at[edge_n - 2]) begin
                    m_mode  = 2;
                    m_start = edge_n;
                end
                default: if ((edge_n - m_start) % TD == 0) begin
                    k = (edge_n - m_start) / TD;
                    if (k == 16 && line_maj(m_start, 8)) begin
                        m_mode = 1;
                    end else if (k == 154) begin
                        for (int j = 0; j < 8; j++) b[j] = line_maj(m_start, 24 + 16 * j);
                        if (line_maj(m_start, 152)) begin
                            dlv    = 1'b1;
                            m_mode = 1;
                        end else begin
                            fail   = 1'b1;
                            m_mode = 0;
                        end
                    end
                end
            endcase
            if (trg) begin
                m_fe = 1'b0;
                m_ov = 1'b0;
            end
            if (dlv) begin
                if (!m_done || trg) begin
                    m_data = b;
                    m_done = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end else if (trg) begin
                m_done = 1'b0;
            end
            if (fail) m_fe = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    int rise_edge = -1;
    int t0_edge   = 0;
    bit done_prev = 1'b0;

    always @(negedge clk) begin
        if (edge_n >= 1) begin
            checks++;
            if ({data_out, done, frame_err, overrun, busy} !==
                {m_data, m_done, m_fe, m_ov, (m_mode == 2)}) begin
                errors++;
                $display("FAIL cycle_compare edge %0d: data/done/fe/ov/busy got %h %b %b %b %b expected %h %b %b %b %b",
                         edge_n, data_out, done, frame_err, overrun, busy,
                         m_data, m_done, m_fe, m_ov, (m_mode == 2));
            end
        end
        if (done === 1'b1 && !done_prev) rise_edge = edge_n;
        done_prev = (done === 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_read();
        @(negedge clk);
        trg = 1'b1;
        @(negedge clk);
        trg = 1'b0;
    endtask

    // Drive one frame; rd_at is the drive offset of a TRG_READ pulse (-1 none),
    // hold_low keeps the line low after a bad stop bit.
    task automatic send(input logic [7:0] b, input bit stop, input int rd_at, input int hold_low);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (c == 0) t0_edge = edge_n;
            rx  = fr[c / BITC];
            trg = (c == rd_at);
        end
        @(negedge clk);
        trg = 1'b0;
        if (hold_low > 0) begin
            rx = 1'b0;
            repeat (hold_low) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b0;
        rx  = 1'b1;
        trg = 1'b0;
        idle(5);
        rst = 1'b1;
        idle(10);
        check("reset_data", int'(data_out), 0);
        check("reset_done", int'(done), 0);
        check("reset_fe", int'(frame_err), 0);
        check("reset_ov", int'(overrun), 0);
        check("reset_busy", int'(busy), 0);

        // 0x55: latency from RX fall drive to DONE is 154 ticks + 3 edges = 619
        rise_edge = -1;
        send(8'h55, 1'b1, -1, 0);
        idle(5);
        check("latency_55", rise_edge - t0_edge, 619);
        check("data_55", int'(data_out), 8'h55);
        check("done_55", int'(done), 1);
        check("fe_55", int'(frame_err), 0);

        // 0xA3, read, then 0x0F
        pulse_read();
        send(8'hA3, 1'b1, -1, 0);
        idle(5);
        check("data_A3", int'(data_out), 8'hA3);
        pulse_read();
        check("done_fall_after_read", int'(done), 0);
        send(8'h0F, 1'b1, -1, 0);
        idle(5);
        check("data_0F", int'(data_out), 8'h0F);
        check("done_0F", int'(done), 1);

        // 3-tick glitch is a false start, then 0x3C
        pulse_read();
        @(negedge clk);
        rx = 1'b0;
        idle(3 * TD);
        rx = 1'b1;
        idle(BITC + 20);
        check("glitch_no_done", int'(done), 0);
        check("glitch_busy", int'(busy), 0);
        send(8'h3C, 1'b1, -1, 0);
        idle(5);
        check("data_3C", int'(data_out), 8'h3C);

        // 0xFF with low stop bit, line held low afterwards
        pulse_read();
        send(8'hFF, 1'b0, -1, 3 * BITC);
        idle(5);
        check("fe_set", int'(frame_err), 1);
        check("fe_no_done", int'(done), 0);
        pulse_read();
        check("fe_cleared", int'(frame_err), 0);

        // overrun, then read in the exact delivery cycle
        send(8'h11, 1'b1, -1, 0);
        idle(10);
        send(8'h22, 1'b1, -1, 0);
        idle(5);
        check("ovr_data", int'(data_out), 8'h11);
        check("ovr_flag", int'(overrun), 1);
        pulse_read();
        send(8'h11, 1'b1, -1, 0);
        idle(10);
        send(8'h22, 1'b1, DLV, 0);
        idle(5);
        check("simul_data", int'(data_out), 8'h22);
        check("simul_done", int'(done), 1);
        check("simul_ov", int'(overrun), 0);

        // reset mid-DATA with line low across release
        @(negedge clk);
        for (int c = 0; c < 4 * BITC + 60; c++) begin
            rx = 1'b0;
            if (c == 3 * BITC)     rst = 1'b0;
            if (c == 3 * BITC + 5) rst = 1'b1;
            @(negedge clk);
        end
        check("rst_low_busy", int'(busy), 0);
        rx = 1'b1;
        idle(2 * BITC);
        check("rst_data", int'(data_out), 0);
        check("rst_done", int'(done), 0);
        send(8'h81, 1'b1, -1, 0);
        idle(5);
        check("data_81", int'(data_out), 8'h81);
        check("done_81", int'(done), 1);

        // randomized frames, reads and gaps
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            bit         stop;
            int         rd;
            int         sel;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            sel  = int'($urandom_range(0, 3));
            rd   = (sel == 1) ? DLV : (sel == 2) ? int'($urandom_range(0, FRAME - 1)) : -1;
            send(b, stop, rd, stop ? 0 : int'($urandom_range(0, BITC)));
            idle(int'($urandom_range(1, BITC)));
            if ($urandom_range(0, 1) == 1) pulse_read();
            idle(int'($urandom_range(1, 2 * BITC)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
